// File: rtl/sound_mix_pkg.sv
// Shared types and sizing helpers for the N-channel sound mixer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sound_mix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } mix_state_t;

  // Accumulator width that cannot overflow: product width plus log2 of the
  // channel count, plus one guard bit.
  function automatic int acc_width(input int w, input int gw, input int nch);
    return w + gw + $clog2(nch) + 1;
  endfunction

endpackage

// File: rtl/sat_unsigned.sv
// Unsigned saturation: narrows IW-bit value to OW bits, clamping to all-ones.
// Latency: combinational.
// Backpressure: none (pure function of input).
module sat_unsigned #(
  parameter int IW = 25,
  parameter int OW = 16
) (
  input  logic [IW-1:0] din,
  output logic [OW-1:0] dout
);

  // Any bit set above the output range means the value cannot be represented.
  assign dout = (|din[IW-1:OW]) ? {OW{1'b1}} : din[OW-1:0];

endmodule

// File: rtl/sound_mixer_n.sv
// N-channel gain mixer: snapshot, serial multiply-accumulate, saturate to W bits.
// Latency: sample_en accepted at edge T -> out/out_valid at edge T+NCH+1.
// Backpressure: none; sample_en while busy is dropped and flags sticky overrun.
module sound_mixer_n
  import sound_mix_pkg::*;
#(
  parameter int NCH      = 6,
  parameter int W        = 16,
  parameter int GW       = 8,
  parameter int GAIN_RST = 2 ** (GW - 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_en,
  input  logic [NCH*W-1:0]       ch_in,
  input  logic [NCH-1:0]         ch_en,
  input  logic                   gain_we,
  input  logic [$clog2(NCH)-1:0] gain_addr,
  input  logic [GW-1:0]          gain_data,
  output logic [W-1:0]           out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int AW = acc_width(W, GW, NCH);
  localparam int IW = $clog2(NCH);

  mix_state_t        state;
  logic [AW-1:0]     acc;
  logic [IW-1:0]     idx;
  logic [NCH*W-1:0]  ch_s;
  logic [NCH-1:0]    ch_en_s;
  logic [GW-1:0]     gain_s    [NCH];
  logic [GW-1:0]     gain_a    [NCH];
  logic [GW-1:0]     gain_next [NCH];
  logic              gain_wr;
  logic [W-1:0]      mac_smp;
  logic [W+GW-1:0]   mac_prod;
  logic [W-1:0]      sat_out;

  // Writes to non-existent channels are dropped.
  assign gain_wr = gain_we && (int'(gain_addr) < NCH);

  // Staged gains take host writes in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) gain_s[k] <= GW'(GAIN_RST);
    end else if (gain_wr) begin
      gain_s[gain_addr] <= gain_data;
    end
  end

  // Staged gains as seen after this edge's write, so a write coinciding
  // with acceptance lands in the active set.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      gain_next[k] = gain_s[k];
      if (gain_wr && (int'(gain_addr) == k)) gain_next[k] = gain_data;
    end
  end

  // Single shared multiplier; muted channels contribute zero.
  assign mac_smp  = ch_en_s[idx] ? ch_s[idx*W +: W] : '0;
  assign mac_prod = {{GW{1'b0}}, mac_smp} * {{W{1'b0}}, gain_a[idx]};

  sat_unsigned #(
    .IW (AW - GW),
    .OW (W)
  ) u_sat (
    .din  (acc[AW-1:GW]),
    .dout (sat_out)
  );

  // Mix sequencer: accept -> NCH accumulate edges -> publish saturated result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      idx       <= '0;
      ch_s      <= '0;
      ch_en_s   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int k = 0; k < NCH; k++) gain_a[k] <= GW'(GAIN_RST);
    end else begin
      out_valid <= 1'b0;
      if (sample_en && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (sample_en) begin
            ch_s    <= ch_in;
            ch_en_s <= ch_en;
            for (int k = 0; k < NCH; k++) gain_a[k] <= gain_next[k];
            acc     <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + {{(AW-W-GW){1'b0}}, mac_prod};
          if (idx == IW'(NCH - 1)) begin
            idx   <= '0;
            state <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: begin
          out       <= sat_out;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sound_mixer_n.sv
// Self-checking bench for sound_mixer_n (NCH=6, W=16, GW=8).
// Reference model: sum of enabled channel*gain products, >>8, clamp to 16 bits.
// Directed corner cases followed by randomized samples and gain writes.
module tb_sound_mixer_n;

  localparam int NCH = 6;
  localparam int W   = 16;
  localparam int GW  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_en = 1'b0;
  logic [NCH*W-1:0]  ch_in = '0;
  logic [NCH-1:0]    ch_en = '0;
  logic              gain_we = 1'b0;
  logic [2:0]        gain_addr = '0;
  logic [GW-1:0]     gain_data = '0;
  logic [W-1:0]      dout;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  // Reference state: staged gains, last published output, sticky overrun.
  int gs [NCH];
  int last_out = 0;
  int model_ovr = 0;

  sound_mixer_n #(.NCH(NCH), .W(W), .GW(GW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .ch_in     (ch_in),
    .ch_en     (ch_en),
    .gain_we   (gain_we),
    .gain_addr (gain_addr),
    .gain_data (gain_data),
    .out       (dout),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mix_ref(input logic [NCH*W-1:0] c, input logic [NCH-1:0] e);
    longint s;
    s = 0;
    for (int k = 0; k < NCH; k++)
      if (e[k]) s += longint'(c[k*W +: W]) * longint'(gs[k]);
    s = s / 256;
    if (s > 65535) s = 65535;
    return int'(s);
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [7:0] d);
    if (int'(a) < NCH) gs[a] = int'(d);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) gs[k] = 128;
    last_out  = 0;
    model_ovr = 0;
  endtask

  task automatic write_gain(input logic [2:0] a, input logic [7:0] d);
    gain_we   = 1'b1;
    gain_addr = a;
    gain_data = d;
    tick();
    gain_we = 1'b0;
    model_write(a, d);
  endtask

  // One mix. wr_at: 0 = gain write coincident with accept, 1..7 = during the
  // mix, <0 = none. se_again: cycle at which a stray sample_en is issued.
  task automatic run_sample(input string tag, input logic [NCH*W-1:0] cin,
                            input logic [NCH-1:0] cen, input int wr_at,
                            input logic [2:0] wa, input logic [7:0] wd,
                            input int se_again);
    int exp;
    chk({tag, ":hold"}, 32'(dout), 32'(last_out));
    ch_in     = cin;
    ch_en     = cen;
    sample_en = 1'b1;
    if (wr_at == 0) begin
      gain_we = 1'b1; gain_addr = wa; gain_data = wd;
      model_write(wa, wd);
    end
    exp = mix_ref(cin, cen);
    tick();
    sample_en = 1'b0;
    gain_we   = 1'b0;
    chk({tag, ":busy0"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 7; i++) begin
      if (i == 1) begin
        ch_in = {$urandom, $urandom, $urandom};
        ch_en = NCH'($urandom);
      end
      sample_en = (i == se_again);
      if (i == se_again) model_ovr = 1;
      gain_we = (i == wr_at);
      gain_addr = wa;
      gain_data = wd;
      if (i == wr_at) model_write(wa, wd);
      tick();
      sample_en = 1'b0;
      gain_we   = 1'b0;
      if (i < 7) begin
        chk({tag, ":vld_lo"}, 32'(out_valid), 32'd0);
        chk({tag, ":busy"}, 32'(busy), 32'd1);
      end else begin
        chk({tag, ":vld"}, 32'(out_valid), 32'd1);
        chk({tag, ":busy_end"}, 32'(busy), 32'd0);
        chk({tag, ":out"}, 32'(dout), 32'(exp));
      end
    end
    last_out = exp;
    tick();
    chk({tag, ":vld_pulse"}, 32'(out_valid), 32'd0);
    chk({tag, ":ovr"}, 32'(overrun), 32'(model_ovr));
  endtask

  initial begin
    logic [NCH*W-1:0] c;
    model_reset();

    // Reset state
    #2;
    chk("rst_out", 32'(dout), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Reset gains, ch0 half-scale
    c = '0; c[15:0] = 16'h8000;
    run_sample("unity_half", c, 6'b111111, -1, 3'd0, 8'd0, -1);

    // All full-scale, all gains 255 -> saturation
    for (int k = 0; k < NCH; k++) write_gain(3'(k), 8'd255);
    run_sample("sat", {NCH{16'hFFFF}}, 6'b111111, -1, 3'd0, 8'd0, -1);

    // Two channels enabled
    run_sample("mute", {NCH{16'h1000}}, 6'b000011, -1, 3'd0, 8'd0, -1);

    // Gain write during a mix takes effect only on the next one
    write_gain(3'd0, 8'd128);
    c = '0; c[15:0] = 16'h8000;
    run_sample("mid_wr_a", c, 6'b111111, 3, 3'd0, 8'd0, -1);
    run_sample("mid_wr_b", c, 6'b111111, -1, 3'd0, 8'd0, -1);

    // Write coincident with accept is used immediately
    run_sample("coinc_wr", c, 6'b000001, 0, 3'd0, 8'd200, -1);

    // Out-of-range address ignored
    write_gain(3'd7, 8'd0);
    write_gain(3'd6, 8'd0);
    run_sample("bad_addr", c, 6'b000001, -1, 3'd0, 8'd0, -1);

    // Stray sample_en while busy: no restart, overrun sticks
    run_sample("ovr", {NCH{16'h2345}}, 6'b101010, -1, 3'd0, 8'd0, 3);
    run_sample("ovr_stay", {NCH{16'h0F0F}}, 6'b111111, -1, 3'd0, 8'd0, -1);

    // Reset in the middle of a mix
    ch_in = {NCH{16'hFFFF}}; ch_en = '1; sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_out", 32'(dout), 32'd0);
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end
    run_sample("post_rst", {NCH{16'h4321}}, 6'b110011, -1, 3'd0, 8'd0, -1);

    // Randomized mixes with random gain writes
    for (int n = 0; n < 25; n++) begin
      int wr;
      wr = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1)
        write_gain(3'($urandom_range(0, 7)), 8'($urandom));
      run_sample("rand", {$urandom, $urandom, $urandom}, NCH'($urandom),
                 (wr == 0) ? -1 : ((wr == 1) ? 0 : int'($urandom_range(1, 7))),
                 3'($urandom_range(0, 7)), 8'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
